// File: rtl/huffman_decoder.sv
// huffman_decoder
//   Receiver side of the Huffman serial link. A code table is loaded one
//   entry per cycle. Each entry holds a symbol, its codeword left-aligned in
//   BIT_WIDTH bits, and the code length. Code bits then arrive MSB-first
//   and are collected in an accumulator. After every accepted bit the table
//   is searched one entry per cycle, and the lowest matching index wins.
//   Each decoded symbol is emitted with a one-cycle sym_valid_o pulse.
//
// Ports
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   tbl_we_i             write one table entry (LOAD only)
//   tbl_sym_i/code_i/len_i   entry symbol, left-aligned codeword, code length
//   tbl_done_i           table complete, start decoding
//   bit_valid_i, bit_i   serial code bit handshake and data
//   bit_ready_o          decoder accepts a bit this cycle
//   stream_end_i         no further bits
//   sym_valid_o, sym_o   decoded symbol pulse and value (sym_o holds)
//   tbl_cnt_o            number of stored table entries
//   done_o, err_o        sticky clean-finish / error flags
//
// Optional build macro
//   HUFF_DEC_SYMCNT_EN   adds sym_cnt_o[15:0], a saturating count of
//                        sym_valid_o pulses since reset
module huffman_decoder #(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_SYM   = 16,
  parameter int LEN_W     = 4,
  parameter int IDX_W     = $clog2(MAX_SYM) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tbl_we_i,
  input  logic [BIT_WIDTH-1:0] tbl_sym_i,
  input  logic [BIT_WIDTH-1:0] tbl_code_i,
  input  logic [LEN_W-1:0]     tbl_len_i,
  input  logic                 tbl_done_i,
  input  logic                 bit_valid_i,
  input  logic                 bit_i,
  output logic                 bit_ready_o,
  input  logic                 stream_end_i,
  output logic                 sym_valid_o,
  output logic [BIT_WIDTH-1:0] sym_o,
  output logic [IDX_W-1:0]     tbl_cnt_o,
  output logic                 done_o,
  output logic                 err_o
`ifdef HUFF_DEC_SYMCNT_EN
  ,
  output logic [15:0]          sym_cnt_o
`endif
);

  localparam int AW = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_DECODE,
    S_SEARCH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_tbl_cnt;
  logic [BIT_WIDTH-1:0]   r_acc;
  logic [LEN_W-1:0]       r_acc_len;
  logic [AW-1:0]          r_idx;
  logic                   r_sym_valid;
  logic [BIT_WIDTH-1:0]   r_sym;
  logic                   r_done;
  logic                   r_err;

  // Table storage: written only while loading, never reset.
  logic [BIT_WIDTH-1:0]   r_tbl_sym  [MAX_SYM];
  logic [BIT_WIDTH-1:0]   r_tbl_code [MAX_SYM];
  logic [LEN_W-1:0]       r_tbl_len  [MAX_SYM];

  logic                   w_wr_ok;
  logic                   w_wr_take;
  logic [IDX_W-1:0]       w_cnt_after;
  logic [LEN_W-1:0]       w_bit_pos;
  logic [BIT_WIDTH-1:0]   w_bit_vec;
  logic                   w_hit;
  logic                   w_last;

  assign w_wr_ok     = (r_tbl_cnt != IDX_W'(MAX_SYM)) && (tbl_len_i != '0) &&
                       (tbl_len_i <= LEN_W'(BIT_WIDTH));
  assign w_wr_take   = (r_state == S_LOAD) && tbl_we_i && w_wr_ok;
  // A write in the same cycle as tbl_done_i counts toward the empty-table check.
  assign w_cnt_after = w_wr_take ? r_tbl_cnt + IDX_W'(1) : r_tbl_cnt;

  // New bit lands just below the bits already collected; lower bits stay 0.
  assign w_bit_pos   = LEN_W'(BIT_WIDTH - 1) - r_acc_len;
  assign w_bit_vec   = BIT_WIDTH'(bit_i) << w_bit_pos;

  assign w_hit       = (r_tbl_len[r_idx] == r_acc_len) && (r_tbl_code[r_idx] == r_acc);
  assign w_last      = (IDX_W'(r_idx) == r_tbl_cnt - IDX_W'(1));

  assign bit_ready_o = (r_state == S_DECODE);
  assign sym_valid_o = r_sym_valid;
  assign sym_o       = r_sym;
  assign tbl_cnt_o   = r_tbl_cnt;
  assign done_o      = r_done;
  assign err_o       = r_err;

  always_ff @(posedge clk_i) begin
    if (w_wr_take) begin
      r_tbl_sym[r_tbl_cnt[AW-1:0]]  <= tbl_sym_i;
      r_tbl_code[r_tbl_cnt[AW-1:0]] <= tbl_code_i;
      r_tbl_len[r_tbl_cnt[AW-1:0]]  <= tbl_len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_LOAD;
      r_tbl_cnt   <= '0;
      r_acc       <= '0;
      r_acc_len   <= '0;
      r_idx       <= '0;
      r_sym_valid <= 1'b0;
      r_sym       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (tbl_we_i) begin
            if (w_wr_ok) r_tbl_cnt <= r_tbl_cnt + IDX_W'(1);
            else         r_err     <= 1'b1;
          end
          if (tbl_done_i) begin
            if (w_cnt_after == '0) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (bit_valid_i) begin
            r_acc     <= r_acc | w_bit_vec;
            r_acc_len <= r_acc_len + LEN_W'(1);
            r_idx     <= '0;
            r_state   <= S_SEARCH;
          end else if (stream_end_i) begin
            if (r_acc_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_sym       <= r_tbl_sym[r_idx];
            r_sym_valid <= 1'b1;
            r_acc       <= '0;
            r_acc_len   <= '0;
            r_state     <= S_DECODE;
          end else if (w_last) begin
            // A full-length accumulator with no match can never match later.
            if (r_acc_len == LEN_W'(BIT_WIDTH)) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DECODE;
            end
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        S_DONE:  r_done <= 1'b1;
        S_ERROR: r_err  <= 1'b1;
        default: r_state <= S_ERROR;
      endcase
    end
  end

`ifdef HUFF_DEC_SYMCNT_EN
  logic [15:0] r_sym_cnt;
  logic        w_sym_fire;

  // Counted on the same edge that raises sym_valid_o, so the count tracks the pulse.
  assign w_sym_fire = (r_state == S_SEARCH) && w_hit;
  assign sym_cnt_o  = r_sym_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  r_sym_cnt <= '0;
    else if (w_sym_fire && r_sym_cnt != 16'hFFFF) r_sym_cnt <= r_sym_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
module tb_huffman_decoder;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tbl_we_i = 1'b0;
  logic [7:0] tbl_sym_i = '0;
  logic [7:0] tbl_code_i = '0;
  logic [3:0] tbl_len_i = '0;
  logic       tbl_done_i = 1'b0;
  logic       bit_valid_i = 1'b0;
  logic       bit_i = 1'b0;
  logic       bit_ready_o;
  logic       stream_end_i = 1'b0;
  logic       sym_valid_o;
  logic [7:0] sym_o;
  logic [4:0] tbl_cnt_o;
  logic       done_o;
  logic       err_o;
`ifdef HUFF_DEC_SYMCNT_EN
  logic [15:0] sym_cnt_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] sym_q[$];

  huffman_decoder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tbl_we_i     (tbl_we_i),
    .tbl_sym_i    (tbl_sym_i),
    .tbl_code_i   (tbl_code_i),
    .tbl_len_i    (tbl_len_i),
    .tbl_done_i   (tbl_done_i),
    .bit_valid_i  (bit_valid_i),
    .bit_i        (bit_i),
    .bit_ready_o  (bit_ready_o),
    .stream_end_i (stream_end_i),
    .sym_valid_o  (sym_valid_o),
    .sym_o        (sym_o),
    .tbl_cnt_o    (tbl_cnt_o),
    .done_o       (done_o),
    .err_o        (err_o)
`ifdef HUFF_DEC_SYMCNT_EN
    ,
    .sym_cnt_o    (sym_cnt_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  // Collect every decoded symbol.
  always @(negedge clk_i) begin
    if (sym_valid_o) sym_q.push_back(sym_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    tbl_we_i = 1'b0; tbl_done_i = 1'b0; bit_valid_i = 1'b0;
    bit_i = 1'b0; stream_end_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    sym_q.delete();
  endtask

  task automatic load(input logic [7:0] s, input logic [7:0] c, input logic [3:0] l);
    @(negedge clk_i);
    tbl_we_i = 1'b1; tbl_sym_i = s; tbl_code_i = c; tbl_len_i = l;
    @(posedge clk_i);
    #1 tbl_we_i = 1'b0;
  endtask

  task automatic finish_tbl();
    @(negedge clk_i);
    tbl_done_i = 1'b1;
    @(posedge clk_i);
    #1 tbl_done_i = 1'b0;
  endtask

  task automatic load_abc();
    load(8'h41, 8'h00, 4'd1);
    load(8'h42, 8'h80, 4'd2);
    load(8'h43, 8'hC0, 4'd2);
    finish_tbl();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk_i);
    while (!bit_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (!bit_ready_o) check("ready_wait", {31'd0, bit_ready_o}, 32'd1);
  endtask

  // Returns 1 time unit after the edge that accepted the bit.
  task automatic send_bit(input logic b);
    wait_ready();
    bit_valid_i = 1'b1; bit_i = b;
    @(posedge clk_i);
    #1 bit_valid_i = 1'b0;
  endtask

  task automatic end_stream();
    wait_ready();
    stream_end_i = 1'b1;
    @(posedge clk_i);
    #1 stream_end_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  logic [7:0] exp_a [4];
  logic [7:0] bits_a [6];

  initial begin
    exp_a  = '{8'h41, 8'h42, 8'h43, 8'h41};
    bits_a = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("rst_sym_valid", {31'd0, sym_valid_o}, 32'd0);
    check("rst_sym",       {24'd0, sym_o},       32'd0);
    check("rst_tbl_cnt",   {27'd0, tbl_cnt_o},   32'd0);
    check("rst_ready",     {31'd0, bit_ready_o}, 32'd0);
    check("rst_done",      {31'd0, done_o},      32'd0);
    check("rst_err",       {31'd0, err_o},       32'd0);

    // A,B,C table; bits 0 10 11 0 decode to A B C A
    load_abc();
    check("abc_tbl_cnt", {27'd0, tbl_cnt_o}, 32'd3);
    foreach (bits_a[i]) send_bit(bits_a[i]);
    end_stream();
    idle(1);
    check("abc_npulse", sym_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("abc_sym%0d", i), (i < sym_q.size()) ? {24'd0, sym_q[i]} : 32'hDEAD, {24'd0, exp_a[i]});
    check("abc_done",  {31'd0, done_o},      32'd1);
    check("abc_err",   {31'd0, err_o},       32'd0);
    check("abc_ready", {31'd0, bit_ready_o}, 32'd0);

    // Incomplete code at end of stream
    do_reset();
    load_abc();
    send_bit(1'b1);
    end_stream();
    idle(2);
    check("trunc_err",    {31'd0, err_o},       32'd1);
    check("trunc_done",   {31'd0, done_o},      32'd0);
    check("trunc_npulse", sym_q.size(),         32'd0);
    check("trunc_ready",  {31'd0, bit_ready_o}, 32'd0);

    // Single full-length entry
    do_reset();
    load(8'h5A, 8'hFF, 4'd8);
    finish_tbl();
    repeat (8) send_bit(1'b1);
    idle(3);
    check("full_npulse", sym_q.size(), 32'd1);
    check("full_sym",    {24'd0, sym_o}, 32'h5A);
    check("full_err0",   {31'd0, err_o}, 32'd0);
    repeat (8) send_bit(1'b0);
    check("full_err_pre", {31'd0, err_o}, 32'd0);
    @(posedge clk_i); #1;
    check("full_err",    {31'd0, err_o},       32'd1);
    check("full_ready",  {31'd0, bit_ready_o}, 32'd0);
    check("full_npulse2", sym_q.size(),        32'd1);

    // Table overflow
    do_reset();
    for (int i = 0; i < 16; i++) load(8'(i), 8'(i << 4), 4'd4);
    idle(1);
    check("ovf_cnt16", {27'd0, tbl_cnt_o}, 32'd16);
    check("ovf_err0",  {31'd0, err_o},     32'd0);
    load(8'hEE, 8'hF0, 4'd4);
    idle(1);
    check("ovf_cnt",   {27'd0, tbl_cnt_o}, 32'd16);
    check("ovf_err",   {31'd0, err_o},     32'd1);
    check("ovf_ready", {31'd0, bit_ready_o}, 32'd0);

    // Empty table
    do_reset();
    finish_tbl();
    idle(1);
    check("empty_err",   {31'd0, err_o},       32'd1);
    check("empty_ready", {31'd0, bit_ready_o}, 32'd0);

    // Illegal lengths are dropped
    do_reset();
    load(8'h11, 8'h00, 4'd0);
    idle(1);
    check("len0_cnt", {27'd0, tbl_cnt_o}, 32'd0);
    check("len0_err", {31'd0, err_o},     32'd1);
    do_reset();
    load(8'h11, 8'h00, 4'd9);
    idle(1);
    check("len9_cnt", {27'd0, tbl_cnt_o}, 32'd0);
    check("len9_err", {31'd0, err_o},     32'd1);

    // Write and done together on an empty table
    do_reset();
    @(negedge clk_i);
    tbl_we_i = 1'b1; tbl_done_i = 1'b1;
    tbl_sym_i = 8'h41; tbl_code_i = 8'h00; tbl_len_i = 4'd1;
    @(posedge clk_i);
    #1 tbl_we_i = 1'b0; tbl_done_i = 1'b0;
    check("wd_cnt",   {27'd0, tbl_cnt_o},   32'd1);
    check("wd_ready", {31'd0, bit_ready_o}, 32'd1);
    check("wd_err",   {31'd0, err_o},       32'd0);

    // Latency: second 1-bit completes code C at table index 2
    do_reset();
    load_abc();
    send_bit(1'b1);
    send_bit(1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("lat_valid_t%0d", c), {31'd0, sym_valid_o}, 32'd0);
      check($sformatf("lat_ready_t%0d", c), {31'd0, bit_ready_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    check("lat_valid_t3", {31'd0, sym_valid_o}, 32'd1);
    check("lat_sym_t3",   {24'd0, sym_o},       32'h43);
    check("lat_ready_t3", {31'd0, bit_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    check("lat_valid_t4", {31'd0, sym_valid_o}, 32'd0);

    // Reset mid-search with bit_valid_i held high
    do_reset();
    load_abc();
    send_bit(1'b0);
    idle(2);
    check("mid_pre_sym", {24'd0, sym_o}, 32'h41);
    @(negedge clk_i);
    bit_valid_i = 1'b1; bit_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("mid_sym",     {24'd0, sym_o},       32'd0);
    check("mid_valid",   {31'd0, sym_valid_o}, 32'd0);
    check("mid_cnt",     {27'd0, tbl_cnt_o},   32'd0);
    check("mid_ready",   {31'd0, bit_ready_o}, 32'd0);
    check("mid_done",    {31'd0, done_o},      32'd0);
    check("mid_err",     {31'd0, err_o},       32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_load_ready", {31'd0, bit_ready_o}, 32'd0);
    check("mid_load_cnt",   {27'd0, tbl_cnt_o},   32'd0);
    bit_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Receiver end of the Huffman serial link: rebuilds the original BIT_WIDTH-bit characters from the MSB-first code bitstream that the encoder emits.
- Before decoding, a code table is loaded, one entry per cycle. Each entry holds the symbol, its codeword left-aligned in BIT_WIDTH bits, and the code length.
- Bits are accumulated and matched against the table by a sequential search. Each decoded symbol is presented with a one-cycle valid pulse to the downstream text buffer.

Parameters:
BIT_WIDTH, 8, symbol width and maximum codeword length
MAX_SYM, 16, code table depth
LEN_W, 4, code length field width; must satisfy 2**LEN_W > BIT_WIDTH
IDX_W, $clog2(MAX_SYM)+1, table count/index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
tbl_we_i  in  1  write one table entry (LOAD state only)
tbl_sym_i  in  BIT_WIDTH  entry symbol
tbl_code_i  in  BIT_WIDTH  entry codeword, left-aligned (first bit = MSB)
tbl_len_i  in  LEN_W  entry code length, 1..BIT_WIDTH
tbl_done_i  in  1  table complete; start decoding
bit_valid_i  in  1  serial bit present
bit_i  in  1  serial code bit
bit_ready_o  out  1  decoder accepts a bit this cycle
stream_end_i  in  1  no further bits (sampled in DECODE)
sym_valid_o  out  1  one-cycle pulse, sym_o valid
sym_o  out  BIT_WIDTH  decoded symbol
tbl_cnt_o  out  IDX_W  number of stored entries
done_o  out  1  stream finished cleanly (sticky)
err_o  out  1  error (sticky)

Behaviour:
- Reset (async, any state, including mid-search): state=LOAD; table count, accumulator, acc length and search index all 0; all outputs 0.
- States: LOAD, DECODE, SEARCH, DONE, ERROR.
- LOAD:
  - tbl_we_i writes entry[tbl_cnt] and increments tbl_cnt_o.
  - Ignored writes: when tbl_cnt_o==MAX_SYM, or when tbl_len_i==0 or >BIT_WIDTH. Either case sets err_o but does not change state.
  - tbl_done_i: go to ERROR if tbl_cnt_o==0, else DECODE.
  - tbl_we_i and tbl_done_i in the same cycle: the write is taken first and counted, then the transition happens.
- DECODE:
  - bit_ready_o=1 combinationally.
  - On bit_valid_i: acc <= acc | (bit_i << (BIT_WIDTH-1-acc_len)), acc_len+1, idx=0, go to SEARCH.
  - Otherwise, on stream_end_i: DONE if acc_len==0, else ERROR.
  - bit_valid_i has priority over stream_end_i in the same cycle.
- SEARCH:
  - bit_ready_o=0. Each cycle compares entry[idx]: match when len==acc_len and code==acc. The lowest index wins.
  - On match: sym_o <= entry.sym, sym_valid_o=1 for exactly one cycle, acc and acc_len cleared, back to DECODE.
  - No match at idx==tbl_cnt-1: go to ERROR if acc_len==BIT_WIDTH, else back to DECODE.
  - Otherwise idx+1.
  - Latency: a bit accepted at edge t with match at index j gives sym_valid_o high in the cycle after edge t+1+j. The next bit is accepted no earlier than that cycle.
- DONE: done_o=1. Only reset leaves DONE.
- ERROR: err_o=1, bit_ready_o=0. Only reset leaves ERROR.
- sym_o holds its last value between pulses. Unused lower acc bits are always 0.

Optional Feature:
HUFF_DEC_SYMCNT_EN:
- When defined: adds output port sym_cnt_o [15:0]. It counts sym_valid_o pulses since reset, saturates at 16'hFFFF, and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Table A(0x41)=0x00/1, B(0x42)=0x80/2, C(0x43)=0xC0/2 loaded, tbl_done_i; bits 0,1,0,1,1,0 then stream_end_i -> sym_o A,B,C,A (four pulses), done_o=1, err_o=0, tbl_cnt_o=3.
- Same table; bits 1 then stream_end_i -> err_o=1, no sym_valid_o, bit_ready_o=0 afterwards.
- Table with a single entry of length BIT_WIDTH (0xFF/8, sym 0x5A); eight 1-bits -> one pulse, sym_o=0x5A. Eight 0-bits -> ERROR after the 8th search completes.
- Load MAX_SYM+1 entries -> tbl_cnt_o=MAX_SYM, err_o=1. tbl_done_i with 0 entries (after reset) -> ERROR.
- Assert rst_i while in SEARCH with bit_valid_i held high -> all outputs 0 immediately, state LOAD, table count 0.
- Latency check: bit accepted at edge t, matching entry at index 2 -> sym_valid_o high in the cycle after edge t+3. bit_ready_o is low throughout the search.
